// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared state type and constants for the ADC conversion sequencer
package adc_seq_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int RESULT_W    = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_DONE,
      CAPTURE,
      HOLDOFF
   } seq_state_t;

endpackage

// File: rtl/adc_result_fifo.sv
// rtl/adc_result_fifo.sv - ADC result FIFO; ADC_SEQ_OVERWRITE_EN makes a full push discard the oldest entry
module adc_result_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;
   logic             do_push;
   logic             adv_rd;
   logic             full_drop;

   assign empty     = (level == '0);
   assign full      = (level == LW'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign full_drop = push & full & ~do_pop;
   assign rdata     = empty ? '0 : mem[rd_ptr];

`ifdef ADC_SEQ_OVERWRITE_EN
   // Full push without a pop: write anyway and slide the read pointer past the oldest entry.
   assign do_push = push;
   assign adv_rd  = do_pop | full_drop;
`else
   assign do_push = push & ~full_drop;
   assign adv_rd  = do_pop;
`endif

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (adv_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !adv_rd) begin
            level <= level + LW'(1);
         end else if (adv_rd && !do_push) begin
            level <= level - LW'(1);
         end
      end
   end

endmodule

// File: rtl/adc_conv_sequencer.sv
// rtl/adc_conv_sequencer.sv - ADC start/capture sequencer with result FIFO; honours ADC_SEQ_OVERWRITE_EN
module adc_conv_sequencer
   import adc_seq_pkg::*;
#(
   parameter int FIFO_DEPTH         = 8,
   parameter int START_PULSE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES     = 4096
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable_in,
   input  logic                        single_shot_in,
   input  logic [15:0]                 period_in,
   output logic                        start_conversion_out,
   input  logic                        conversion_finished_in,
   input  logic [RESULT_W-1:0]         result_in,
   output logic                        rd_valid_out,
   input  logic                        rd_ready_in,
   output logic [RESULT_W-1:0]         rd_data_out,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
   output logic                        busy_out,
   output logic                        overflow_out,
   output logic                        timeout_out,
   input  logic                        clear_flags_in
);
   localparam int             WCW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]     PULSE_LAST = 4'(START_PULSE_CYCLES - 1);
   localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT_CYCLES - 1);

   seq_state_t             state;
   logic [3:0]             pulse_cnt;
   logic [WCW-1:0]         wait_cnt;
   logic [15:0]            period_cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   done_prev;
   logic                   done_pulse;
   logic                   period_reached;
   logic                   timeout_set;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   overflow_set;

   assign done_pulse     = sync_q[SYNC_STAGES-1] & ~done_prev;
   // cnt + 1 >= period also covers period 0 and 1 without underflow.
   assign period_reached = ({1'b0, period_cnt} + 17'd1) >= {1'b0, period_in};
   assign timeout_set    = (state == WAIT_DONE) && !done_pulse && (wait_cnt == WAIT_LAST);
   assign fifo_push      = (state == CAPTURE);
   assign fifo_pop       = rd_ready_in & ~fifo_empty;
   assign overflow_set   = fifo_push & fifo_full & ~fifo_pop;
   assign rd_valid_out   = ~fifo_empty;
   assign busy_out       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                <= IDLE;
         start_conversion_out <= 1'b0;
         pulse_cnt            <= '0;
         wait_cnt             <= '0;
         period_cnt           <= '0;
         sync_q               <= '0;
         done_prev            <= 1'b0;
         overflow_out         <= 1'b0;
         timeout_out          <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], conversion_finished_in};
         done_prev <= sync_q[SYNC_STAGES-1];

         if (period_cnt != 16'hFFFF) begin
            period_cnt <= period_cnt + 16'd1;
         end

         case (state)
            IDLE: begin
               period_cnt <= '0;
               if (enable_in || single_shot_in) begin
                  state                <= START;
                  start_conversion_out <= 1'b1;
                  pulse_cnt            <= '0;
               end
            end
            START: begin
               if (pulse_cnt == PULSE_LAST) begin
                  state                <= WAIT_DONE;
                  start_conversion_out <= 1'b0;
                  wait_cnt             <= '0;
               end else begin
                  pulse_cnt <= pulse_cnt + 4'd1;
               end
            end
            WAIT_DONE: begin
               if (done_pulse) begin
                  state <= CAPTURE;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= HOLDOFF;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            CAPTURE: begin
               state <= HOLDOFF;
            end
            HOLDOFF: begin
               if (!enable_in) begin
                  state <= IDLE;
               end else if (period_reached) begin
                  state                <= START;
                  start_conversion_out <= 1'b1;
                  pulse_cnt            <= '0;
                  period_cnt           <= '0;
               end
            end
            default: begin
               state                <= IDLE;
               start_conversion_out <= 1'b0;
            end
         endcase

         if (overflow_set) begin
            overflow_out <= 1'b1;
         end else if (clear_flags_in) begin
            overflow_out <= 1'b0;
         end
         if (timeout_set) begin
            timeout_out <= 1'b1;
         end else if (clear_flags_in) begin
            timeout_out <= 1'b0;
         end
      end
   end

   adc_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RESULT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (result_in),
      .rdata (rd_data_out),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level_out)
   );

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb/tb_adc_conv_sequencer.sv - self-checking bench for adc_conv_sequencer (honours ADC_SEQ_OVERWRITE_EN)
module tb_adc_conv_sequencer;
   localparam int DEPTH = 8;
   localparam int SPC   = 4;
   localparam int TMO   = 64;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable_in = 1'b0;
   logic          single_shot_in = 1'b0;
   logic [15:0]   period_in = '0;
   logic          start_conversion_out;
   logic          conversion_finished_in = 1'b0;
   logic [15:0]   result_in = '0;
   logic          rd_valid_out;
   logic          rd_ready_in = 1'b0;
   logic [15:0]   rd_data_out;
   logic [LW-1:0] fifo_level_out;
   logic          busy_out;
   logic          overflow_out;
   logic          timeout_out;
   logic          clear_flags_in = 1'b0;

   always #5 clk = ~clk;

   adc_conv_sequencer #(
      .FIFO_DEPTH         (DEPTH),
      .START_PULSE_CYCLES (SPC),
      .TIMEOUT_CYCLES     (TMO)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .enable_in              (enable_in),
      .single_shot_in         (single_shot_in),
      .period_in              (period_in),
      .start_conversion_out   (start_conversion_out),
      .conversion_finished_in (conversion_finished_in),
      .result_in              (result_in),
      .rd_valid_out           (rd_valid_out),
      .rd_ready_in            (rd_ready_in),
      .rd_data_out            (rd_data_out),
      .fifo_level_out         (fifo_level_out),
      .busy_out               (busy_out),
      .overflow_out           (overflow_out),
      .timeout_out            (timeout_out),
      .clear_flags_in         (clear_flags_in)
   );

`ifdef ADC_SEQ_OVERWRITE_EN
   localparam bit OW = 1'b1;
`else
   localparam bit OW = 1'b0;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;

   // reference model: result queue, sticky flags, scheduled capture/timeout edges
   logic [15:0] q[$];
   bit          m_ovf = 1'b0;
   bit          m_tmo = 1'b0;
   int          cap_cyc = -1;
   int          tmo_cyc = -1;
   logic [15:0] cap_val = '0;
   int          m_caps = 0;

   // ADC behaviour and start-pulse observation
   int          conv_time = 30;
   bit          adc_mute = 1'b0;
   int          val_mode = 0;
   logic [15:0] next_val = '0;
   logic [15:0] fixed_val = '0;
   logic [15:0] adc_val = '0;
   int          adc_cnt = 0;
   bit          adc_prev = 1'b0;
   bit          conv_live = 1'b0;
   int          fin_cyc = 0;
   int          last_start = -1;
   int          last_dur = 0;
   int          run = 0;
   int          n_starts = 0;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit pop, push, ovf_ev, tmo_ev;
      if (!rst_n) begin
         q.delete();
         m_ovf = 1'b0; m_tmo = 1'b0;
         cap_cyc = -1; tmo_cyc = -1;
         conv_live = 1'b0; run = 0; last_start = -1; adc_prev = 1'b0;
         return;
      end
      pop    = rd_ready_in && (q.size() > 0);
      push   = (cyc == cap_cyc);
      ovf_ev = push && (q.size() == DEPTH) && !pop;
      tmo_ev = (cyc == tmo_cyc);
      if (pop) void'(q.pop_front());
      if (push) begin
         m_caps++;
         if (!ovf_ev) begin
            q.push_back(cap_val);
         end else if (OW) begin
            void'(q.pop_front());
            q.push_back(cap_val);
         end
      end
      if (ovf_ev) m_ovf = 1'b1; else if (clear_flags_in) m_ovf = 1'b0;
      if (tmo_ev) m_tmo = 1'b1; else if (clear_flags_in) m_tmo = 1'b0;
   endtask

   task automatic adc_model();
      if (start_conversion_out && !adc_prev) begin
         n_starts++;
         if (last_start >= 0)
            check("start_gap", cyc - last_start, imax(int'(period_in), last_dur));
         last_start = enable_in ? cyc : -1;
         last_dur   = adc_mute ? (SPC + TMO + 1) : (conv_time + 5);
         conversion_finished_in = 1'b0;
         adc_cnt   = conv_time;
         conv_live = 1'b1;
         case (val_mode)
            0:       adc_val = 16'($urandom);
            1:       begin adc_val = next_val; next_val++; end
            default: adc_val = fixed_val;
         endcase
         if (adc_mute) tmo_cyc = cyc + SPC + TMO;
      end else if (adc_cnt > 0) begin
         adc_cnt--;
         if (adc_cnt == 0 && !adc_mute) begin
            conversion_finished_in = 1'b1;
            result_in = adc_val;
            fin_cyc   = cyc;
            if (conv_live) begin
               cap_cyc = cyc + 4;
               cap_val = adc_val;
            end
         end
      end
      if (start_conversion_out) begin
         run++;
      end else if (adc_prev) begin
         check("start_width", run, SPC);
         run = 0;
      end
      adc_prev = start_conversion_out;
   endtask

   task automatic compare_all();
      check("rd_valid", rd_valid_out, q.size() > 0);
      check("rd_data", rd_data_out, (q.size() > 0) ? q[0] : 16'h0000);
      check("level", fifo_level_out, q.size());
      check("overflow", overflow_out, m_ovf);
      check("timeout", timeout_out, m_tmo);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      adc_model();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy_out; i++) step();
      check("idle", busy_out, 1'b0);
   endtask

   task automatic drain();
      rd_ready_in = 1'b1;
      repeat (DEPTH + 2) step();
      rd_ready_in = 1'b0;
      check("drained", fifo_level_out, 0);
   endtask

   task automatic stop_enable();
      enable_in  = 1'b0;
      last_start = -1;
   endtask

   initial begin
      // reset
      repeat (3) step();
      check("rst_start", start_conversion_out, 1'b0);
      check("rst_busy", busy_out, 1'b0);
      rst_n = 1'b1;
      step();

      // single shot, result A5C3 after 40 cycles
      val_mode = 2; fixed_val = 16'hA5C3; conv_time = 40;
      single_shot_in = 1'b1;
      step();
      single_shot_in = 1'b0;
      check("ss_start", start_conversion_out, 1'b1);
      check("ss_busy", busy_out, 1'b1);
      for (int i = 0; i < 200 && !rd_valid_out; i++) step();
      check("ss_valid_lat", cyc - fin_cyc, 4);
      check("ss_data", rd_data_out, 16'hA5C3);
      wait_idle(100);
      drain();

      // periodic, period 100, conversion 30, no reads
      val_mode = 1; next_val = 16'h0100; period_in = 16'd100; conv_time = 30;
      n_starts = 0;
      enable_in = 1'b1;
      repeat (1000) step();
      check("per_starts", n_starts, 10);
      check("per_level", fifo_level_out, DEPTH);
      check("per_ovf", overflow_out, 1'b1);
      stop_enable();
      wait_idle(200);

      // full FIFO with a read on the capture edge
      clear_flags_in = 1'b1;
      step();
      clear_flags_in = 1'b0;
      check("clr_ovf", overflow_out, 1'b0);
      single_shot_in = 1'b1;
      step();
      single_shot_in = 1'b0;
      for (int i = 0; i < 200 && cap_cyc != cyc + 1; i++) step();
      rd_ready_in = 1'b1;
      step();
      rd_ready_in = 1'b0;
      check("fr_level", fifo_level_out, DEPTH);
      check("fr_ovf", overflow_out, 1'b0);
      check("fr_head", rd_data_out, OW ? 16'h0103 : 16'h0101);
      wait_idle(100);
      drain();

      // timeout: ADC never finishes
      adc_mute = 1'b1; period_in = 16'd100; conv_time = 20;
      enable_in = 1'b1;
      repeat (70) step();
      check("tmo_flag", timeout_out, 1'b1);
      check("tmo_nowrite", fifo_level_out, 0);
      adc_mute = 1'b0;
      repeat (60) step();
      stop_enable();
      wait_idle(200);

      // reset in the middle of WAIT_DONE; the late finish must be ignored
      conv_time = 40;
      single_shot_in = 1'b1;
      step();
      single_shot_in = 1'b0;
      repeat (10) step();
      rst_n = 1'b0;
      step();
      check("mr_start", start_conversion_out, 1'b0);
      check("mr_busy", busy_out, 1'b0);
      check("mr_level", fifo_level_out, 0);
      check("mr_tmo", timeout_out, 1'b0);
      rst_n = 1'b1;
      repeat (60) step();
      check("mr_late_busy", busy_out, 1'b0);
      check("mr_late_level", fifo_level_out, 0);

      // randomized batches
      val_mode = 0;
      for (int b = 0; b < 5; b++) begin
         period_in = 16'($urandom_range(0, 60));
         enable_in = 1'b1;
         for (int i = 0; i < 300; i++) begin
            conv_time      = $urandom_range(5, 40);
            rd_ready_in    = ($urandom_range(0, 3) == 0);
            clear_flags_in = ($urandom_range(0, 31) == 0);
            step();
         end
         rd_ready_in = 1'b0;
         clear_flags_in = 1'b0;
         stop_enable();
         wait_idle(200);
         drain();
      end

      // nine back-to-back captures of 1..9 with no reads
      clear_flags_in = 1'b1;
      step();
      clear_flags_in = 1'b0;
      val_mode = 1; next_val = 16'd1; period_in = 16'd0; conv_time = 10;
      m_caps = 0;
      enable_in = 1'b1;
      for (int i = 0; i < 400 && m_caps < 9; i++) step();
      stop_enable();
      wait_idle(100);
      check("ow_ovf", overflow_out, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         check("ow_drain", rd_data_out, (OW ? 2 : 1) + i);
         rd_ready_in = 1'b1;
         step();
         rd_ready_in = 1'b0;
      end
      check("ow_empty", rd_valid_out, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
- Digital sequencer that sits directly around the ADC top level, on its conversion-control and result interface.
- Issues start_conversion pulses, either periodically or on single-shot request.
- Synchronizes the self-timed conversion_finished flag into the system clock domain and captures each 16-bit result into a small FIFO.
- Downstream logic (e.g. a Wishbone/register bank) drains the FIFO through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, result FIFO entries; power of two, 2..64.
- START_PULSE_CYCLES, 4, width of start_conversion_out pulse in clk cycles (1..15).
- TIMEOUT_CYCLES, 4096, max clk cycles in WAIT_DONE before aborting.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable_in  in  1  1 = continuous periodic conversions.
- single_shot_in  in  1  1-cycle request for one conversion (honoured only when enable_in=0 and state IDLE).
- period_in  in  16  clk cycles between successive start pulses (rising edge to rising edge).
- start_conversion_out  out  1  to ADC start_conversion input.
- conversion_finished_in  in  1  from ADC; asynchronous level; high = result valid.
- result_in  in  16  ADC result; stable while conversion_finished_in high.
- rd_valid_out  out  1  FIFO non-empty.
- rd_ready_in  in  1  consumer accepts head entry.
- rd_data_out  out  16  FIFO head entry; 16'h0000 when empty.
- fifo_level_out  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy_out  out  1  state != IDLE.
- overflow_out  out  1  sticky: a result was dropped or overwritten.
- timeout_out  out  1  sticky: WAIT_DONE timed out.
- clear_flags_in  in  1  clears overflow_out and timeout_out.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state IDLE; all outputs 0; FIFO pointers, level, period counter and synchronizer cleared.
  - Reset mid-conversion aborts the conversion; start_conversion_out drops on the same edge.
- conversion_finished_in: 2-flop synchronizer, then rising-edge detect → done_pulse (sync latency 2 cycles, plus 1 for the edge).
- States:
  - IDLE: go to START if enable_in=1, or if single_shot_in=1 with enable_in=0. Period counter loads 0.
  - START: start_conversion_out=1 for exactly START_PULSE_CYCLES cycles, then WAIT_DONE.
  - WAIT_DONE: on done_pulse go to CAPTURE. If the wait counter reaches TIMEOUT_CYCLES, set timeout_out and go to HOLDOFF without writing.
  - CAPTURE: one cycle; write result_in into FIFO; then HOLDOFF.
  - HOLDOFF:
    - If enable_in=0, go to IDLE.
    - Otherwise go to START once the period counter (running since START entry) reaches >= period_in-1.
    - period_in=0 or 1, or a period shorter than the conversion time: go to START on the next cycle (back-to-back operation).
- done_pulse arriving outside WAIT_DONE is ignored.
- Dropping enable_in mid-conversion finishes the current conversion (captures it), then IDLE.
- period_in is sampled continuously; changes take effect at the next HOLDOFF compare.
- FIFO:
  - write on CAPTURE; read when rd_valid_out & rd_ready_in.
  - rd_data_out combinationally reflects the head entry.
  - Full with write and no read: entry dropped, overflow_out set, level stays FIFO_DEPTH.
  - Full with simultaneous read and write: both occur, level unchanged, no overflow.
  - Empty: a read request is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- clear_flags_in=1 clears both sticky flags. A set event in the same cycle wins (flag remains 1).

Optional Feature:
- ADC_SEQ_OVERWRITE_EN defined: on a write to a full FIFO without a simultaneous read, the oldest entry is discarded (read pointer advances) and the new result is stored. overflow_out is still set.
- Not defined: the newest result is dropped, as described above.

Decomposition:
- Package adc_seq_pkg: state enum (IDLE, START, WAIT_DONE, CAPTURE, HOLDOFF), SYNC_STAGES=2, RESULT_W=16.
- Sub-module adc_result_fifo (parameterized depth/width; push, pop, full, empty, level; overwrite mode under the macro). The sequencer FSM, synchronizer and counters stay in the top module.

Test Plan:
- Single shot, enable_in=0: pulse single_shot_in; model finishes 40 cycles after start with result 16'hA5C3 → start pulse high 4 cycles; rd_valid_out rises 4 cycles after finished rises; rd_data_out=16'hA5C3; busy_out returns 0.
- Periodic, period_in=100, conversion time 30: over 1000 cycles → start rising edges exactly 100 cycles apart; 10 results in order; fifo_level_out capped at 8 with rd_ready_in=0; overflow_out=1 after the 9th capture.
- Full plus simultaneous read: FIFO at 8, rd_ready_in=1 on the capture cycle → level stays 8, overflow_out=0, head advances.
- Timeout: model never asserts finished, TIMEOUT_CYCLES=64 → timeout_out=1 after 64 cycles in WAIT_DONE; no FIFO write; next start issued per period.
- Reset mid-WAIT_DONE: rst_n=0 for 1 cycle → next cycle all outputs 0, state IDLE; a late conversion_finished_in is ignored.
- With ADC_SEQ_OVERWRITE_EN: 9 captures of values 1..9 with no reads → FIFO drains 2..9, overflow_out=1.
